// File: rtl/mem_ctrl_ram_if.sv
// Memory-side bus between the datapath (MAR/MDR/strobes) and mem_ctrl_ram.
// master = datapath/sequencer side, slave = memory controller side.
interface mem_ctrl_ram_if #(
    parameter int DATA_W = 32
);
    logic [31:0]       mar_in;
    logic [DATA_W-1:0] mdr_in;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] MDatain;
    logic              mem_ready;
    logic              busy;
    logic              req_err;
    logic              addr_err;

    // Strobes are levels; a request starts on their rising edge and completes
    // with a single-cycle mem_ready pulse (read data valid in that cycle).
    modport master (
        output mar_in, mdr_in, read, write,
        input  MDatain, mem_ready, busy, req_err, addr_err
    );

    modport slave (
        input  mar_in, mdr_in, read, write,
        output MDatain, mem_ready, busy, req_err, addr_err
    );
endinterface

// File: rtl/mem_ctrl_ram.sv
// Word-addressed RAM with an IDLE/WAIT/ACCESS/DONE access FSM and configurable wait states.
// Optional out-of-range address check is enabled by defining MEM_ADDR_CHECK_EN.
module mem_ctrl_ram #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic           clk,
    input  logic           clr,
    mem_ctrl_ram_if.slave  bus,
    output logic [1:0]     o_dbg_state
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

    localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

    state_t              r_state;
    state_t              w_next;
    logic                r_read_q;
    logic                r_write_q;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_dir_wr;
    logic                r_bad;
    logic [DATA_W-1:0]   r_mdat;
    logic                r_mem_ready;
    logic                r_req_err;
    logic                r_addr_err;
    logic [DATA_W-1:0]   r_mem [2**ADDR_W];

    logic                w_rd_start;
    logic                w_wr_start;
    logic                w_accept;
    logic                w_collide;
    logic                w_bad;

    assign w_rd_start = bus.read & ~r_read_q;
    assign w_wr_start = bus.write & ~r_write_q;
    assign w_accept   = (r_state == S_IDLE) && (w_rd_start ^ w_wr_start);
    assign w_collide  = (r_state == S_IDLE) && w_rd_start && w_wr_start;

`ifdef MEM_ADDR_CHECK_EN
    assign w_bad = |bus.mar_in[31:ADDR_W];
`else
    logic w_unused_hi;
    assign w_unused_hi = ^bus.mar_in[31:ADDR_W];
    assign w_bad       = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_bad)                 w_next = S_DONE;
                    else if (WAIT_STATES == 0) w_next = S_ACCESS;
                    else                       w_next = S_WAIT;
                end
            end
            S_WAIT:   if (r_cnt <= 4'd1) w_next = S_ACCESS;
            S_ACCESS: w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state     <= S_IDLE;
            r_read_q    <= 1'b0;
            r_write_q   <= 1'b0;
            r_cnt       <= '0;
            r_mdat      <= '0;
            r_mem_ready <= 1'b0;
            r_req_err   <= 1'b0;
            r_addr_err  <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_read_q    <= bus.read;
            r_write_q   <= bus.write;
            r_mem_ready <= (r_state == S_DONE);
            r_addr_err  <= (r_state == S_DONE) && r_bad;
            r_req_err   <= w_collide;
            if (w_accept)
                r_cnt <= WS_INIT;
            else if (r_state == S_WAIT)
                r_cnt <= r_cnt - 4'd1;
            if (r_state == S_ACCESS && !r_dir_wr)
                r_mdat <= r_mem[r_addr];
        end
    end

    // Transaction operands are captured only on acceptance; they need no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr   <= bus.mar_in[ADDR_W-1:0];
            r_wdata  <= bus.mdr_in;
            r_dir_wr <= w_wr_start;
            r_bad    <= w_bad;
        end
    end

    // A reset on the ACCESS exit edge cancels the pending write.
    always_ff @(posedge clk) begin
        if (clr && r_state == S_ACCESS && r_dir_wr)
            r_mem[r_addr] <= r_wdata;
    end

    assign bus.MDatain   = r_mdat;
    assign bus.mem_ready = r_mem_ready;
    assign bus.busy      = (r_state == S_WAIT) || (r_state == S_ACCESS);
    assign bus.req_err   = r_req_err;
    assign bus.addr_err  = r_addr_err;
    assign o_dbg_state   = r_state;
endmodule

// File: doc/mem_ctrl_ram.md
Name: mem_ctrl_ram

Overview:
Word-addressed 32-bit memory subsystem with an internal RAM array. It consumes the datapath's MAR address, MDR write data and Read/Write strobes, and sits directly upstream of the MDR input mux. It runs an access FSM with configurable wait states and returns read data on MDatain with a one-cycle mem_ready completion pulse, which the control sequencer uses to advance.

Parameters:
ADDR_W, 9, RAM address width; the array holds 2^ADDR_W words.
DATA_W, 32, word width; must match the bus width.
WAIT_STATES, 1, number of idle cycles inserted before the RAM access cycle (0..15).

Ports:
clk  input  1  system clock; all state changes on the rising edge.
clr  input  1  synchronous, active-low reset.
mar_in  input  32  address from MAR; bits [ADDR_W-1:0] index the RAM.
mdr_in  input  DATA_W  write data from MDR.
read  input  1  read request, level; start is its rising edge.
write  input  1  write request, level; start is its rising edge.
MDatain  output  DATA_W  read data to the MDR mux; registered.
mem_ready  output  1  one-cycle pulse when an access completes.
busy  output  1  high in WAIT and ACCESS.
req_err  output  1  one-cycle pulse when read and write rise on the same edge.
addr_err  output  1  out-of-range flag; see Optional Feature.

Behaviour:
- Reset (clr=0 at an edge):
  - state goes to IDLE; MDatain=0, mem_ready=0, busy=0, req_err=0, addr_err=0; edge-detect registers read_q and write_q are cleared.
  - Reset overrides all other activity on the same edge.
  - RAM contents are not reset; the array is zero at time 0.
- Start detection:
  - rd_start = read & ~read_q; wr_start = write & ~write_q.
  - read_q and write_q update every edge.
  - A level held across reset release counts as a new start.
- FSM states are IDLE, WAIT, ACCESS and DONE.
  - IDLE: on rd_start xor wr_start, latch addr=mar_in[ADDR_W-1:0], wdata=mdr_in and dir, then go to WAIT (cnt=WAIT_STATES). If WAIT_STATES=0, go directly to ACCESS.
  - IDLE: if rd_start and wr_start occur together, req_err=1 for the next cycle, no access, stay in IDLE.
  - WAIT: cnt decrements each edge; at cnt==1, go to ACCESS.
  - ACCESS: one cycle.
    - On the exit edge, a write stores wdata into RAM[addr].
    - A read loads MDatain <= RAM[addr].
    - Then go to DONE.
  - DONE: mem_ready=1 and busy=0 for exactly one cycle, then go to IDLE.
- Latency: starts sampled at edge E0 give mem_ready high in the cycle following edge E0+WAIT_STATES+2. Read data is valid in that same cycle.
- Starts seen outside IDLE, including DONE, are dropped with no queue and no error.
- MDatain holds its last read value; writes never change it.
- Reset in WAIT or ACCESS aborts the transaction: the pending write is not performed and no mem_ready is issued.
- Address wrap: upper mar_in bits are ignored unless the optional feature is enabled.
- Read-after-write to the same address returns the new data, because the accesses are sequential.

Optional Feature:
- Macro: MEM_ADDR_CHECK_EN.
- Defined:
  - At acceptance, if mar_in[31:ADDR_W] != 0, go IDLE to DONE directly with no RAM access and MDatain unchanged.
  - addr_err=1 together with the mem_ready pulse (1 cycle).
  - Latency for this path is 1 edge.
- Undefined: addr_err tied to 0 and the address wraps modulo 2^ADDR_W.

Test Plan:
1. WAIT_STATES=1: write 0xDEADBEEF to mar_in=0x05, then read 0x05. Required: each mem_ready pulse arrives 3 edges after the start edge; MDatain=0xDEADBEEF; busy high for 2 cycles.
2. read held high for 10 cycles at addr 0x05. Required: exactly one mem_ready pulse; MDatain stable afterwards.
3. read and write rise on the same edge. Required: req_err pulses 1 cycle; no mem_ready; a subsequent read of the target address returns the old value.
4. Start a write of 0x12345678 to 0x10, then set clr=0 during WAIT. Required: all outputs 0 next cycle; a subsequent read of 0x10 returns 0x00000000.
5. mar_in=0x00000200 with ADDR_W=9, write 0xA5A5A5A5.
   - With MEM_ADDR_CHECK_EN: addr_err=1 with mem_ready, and RAM[0] stays 0.
   - Without it: RAM[0] becomes 0xA5A5A5A5.
6. WAIT_STATES=0 and WAIT_STATES=3, read of a preloaded address. Required: mem_ready arrives at 2 edges and 5 edges after the start respectively.
